// File: rtl/mc_ctrl_pkg.sv
// Purpose: shared types and encodings for the multi-cycle MIPS main control FSM.
//   Contents: FSM state enum, opcode constants, ALUOp / ALUSrcB / PCSource and
//   trap_cause encodings.
// Configuration: CTRL_JUMP_EN adds the JUMP state to the state enum.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
`ifdef CTRL_JUMP_EN
        StJump   = 4'd11,
`endif
        StTrap   = 4'd12
    } mc_state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    localparam logic [1:0] CauseNone    = 2'b00;
    localparam logic [1:0] CauseIllegal = 2'b01;
    localparam logic [1:0] CauseTimeout = 2'b10;

endpackage

// File: rtl/mc_opcode_class.sv
// Purpose: combinational opcode classifier for the multi-cycle control FSM.
// Ports:
//   i_opcode  - 6-bit instruction opcode
//   o_rtype, o_load, o_store, o_beq, o_addi, o_jump - one-hot class flags
//   o_illegal - opcode not supported by this build
// Configuration: without CTRL_JUMP_EN the jump opcode is classed as illegal.
module mc_opcode_class
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    output logic       o_rtype,
    output logic       o_load,
    output logic       o_store,
    output logic       o_beq,
    output logic       o_addi,
    output logic       o_jump,
    output logic       o_illegal
);

    always_comb begin
        o_rtype   = 1'b0;
        o_load    = 1'b0;
        o_store   = 1'b0;
        o_beq     = 1'b0;
        o_addi    = 1'b0;
        o_jump    = 1'b0;
        o_illegal = 1'b0;
        case (i_opcode)
            OpRtype: o_rtype = 1'b1;
            OpLw:    o_load  = 1'b1;
            OpSw:    o_store = 1'b1;
            OpBeq:   o_beq   = 1'b1;
            OpAddi:  o_addi  = 1'b1;
`ifdef CTRL_JUMP_EN
            OpJ:     o_jump  = 1'b1;
`endif
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Purpose: multi-cycle MIPS main control FSM. Sequences fetch/decode/execute/
//   memory/write-back per instruction and drives the datapath selects, with a
//   memory-ready handshake, wait watchdog, trap on illegal opcode and a
//   retired-instruction counter.
// Ports:
//   clk, rst (sync, active-high), instrWord (sampled in DECODE), mem_ready
//   datapath controls: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite
//     MemToReg RegDest RegWrite ALUSrcA ALUSrcB ALUOp PCSource
//   status: trap, trap_cause, instr_count
// Configuration: CTRL_JUMP_EN enables the j instruction (JUMP state).
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned INSTR_W      = 32,
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instrWord,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemToReg,
    output logic               RegDest,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [CNT_W-1:0]   instr_count
);

    localparam int unsigned WaitW = $clog2(MEM_WAIT_MAX + 1);

    mc_state_e        r_state;
    logic [WaitW-1:0] r_wait_cnt;
    logic [CNT_W-1:0] r_instr_count;
    logic [1:0]       r_trap_cause;
    logic             r_is_store;

    logic w_rtype, w_load, w_store, w_beq, w_addi, w_jump, w_illegal;
    logic w_wait_max;
    logic w_unused;

    mc_opcode_class u_opcode_class (
        .i_opcode  (instrWord[INSTR_W-1 -: 6]),
        .o_rtype   (w_rtype),
        .o_load    (w_load),
        .o_store   (w_store),
        .o_beq     (w_beq),
        .o_addi    (w_addi),
        .o_jump    (w_jump),
        .o_illegal (w_illegal)
    );

    assign w_unused   = ^{instrWord[INSTR_W-7:0], w_jump, w_illegal};
    assign w_wait_max = (r_wait_cnt == WaitW'(MEM_WAIT_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StFetch;
            r_wait_cnt    <= '0;
            r_instr_count <= '0;
            r_trap_cause  <= CauseNone;
            r_is_store    <= 1'b0;
        end else begin
            // Counter only survives while waiting in a memory state; every other
            // path (entry, completion) leaves it cleared.
            r_wait_cnt <= '0;
            case (r_state)
                StFetch, StMemRd, StMemWr: begin
                    if (mem_ready) begin
                        if (r_state == StFetch) begin
                            r_state <= StDecode;
                        end else if (r_state == StMemRd) begin
                            r_state <= StMemWb;
                        end else begin
                            r_state       <= StFetch;
                            r_instr_count <= r_instr_count + CNT_W'(1);
                        end
                    end else if (w_wait_max) begin
                        r_state      <= StTrap;
                        r_trap_cause <= CauseTimeout;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WaitW'(1);
                    end
                end
                StDecode: begin
                    r_is_store <= w_store;
                    if (w_rtype) begin
                        r_state <= StExec;
                    end else if (w_load || w_store) begin
                        r_state <= StMemAdr;
                    end else if (w_beq) begin
                        r_state <= StBranch;
                    end else if (w_addi) begin
                        r_state <= StAddiEx;
`ifdef CTRL_JUMP_EN
                    end else if (w_jump) begin
                        r_state <= StJump;
`endif
                    end else begin
                        r_state      <= StTrap;
                        r_trap_cause <= CauseIllegal;
                    end
                end
                StMemAdr: r_state <= r_is_store ? StMemWr : StMemRd;
                StExec:   r_state <= StAluWb;
                StAddiEx: r_state <= StAddiWb;
`ifdef CTRL_JUMP_EN
                StJump,
`endif
                StMemWb, StAluWb, StAddiWb, StBranch: begin
                    r_state       <= StFetch;
                    r_instr_count <= r_instr_count + CNT_W'(1);
                end
                StTrap:   r_state <= StTrap;
                default:  r_state <= StFetch;
            endcase
        end
    end

    // Moore decode of the registered state; only FETCH looks at mem_ready so
    // IR and PC load exactly in the cycle the read completes.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDest     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SrcBReg;
        ALUOp       = AluAdd;
        PCSource    = PcAlu;
        trap        = 1'b0;
        trap_cause  = CauseNone;
        instr_count = '0;
        if (!rst) begin
            trap_cause  = r_trap_cause;
            instr_count = r_instr_count;
            unique case (r_state)
                StFetch: begin
                    MemRead = 1'b1;
                    ALUSrcB = SrcBFour;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                StDecode: ALUSrcB = SrcBImmSh;
                StMemAdr, StAddiEx: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SrcBImm;
                end
                StMemRd: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                StMemWb: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                StMemWr: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                StExec: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = AluFunct;
                end
                StAluWb: begin
                    RegWrite = 1'b1;
                    RegDest  = 1'b1;
                end
                StBranch: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = AluSub;
                    PCWriteCond = 1'b1;
                    PCSource    = PcAluOut;
                end
                StAddiWb: RegWrite = 1'b1;
`ifdef CTRL_JUMP_EN
                StJump: begin
                    PCWrite  = 1'b1;
                    PCSource = PcJump;
                end
`endif
                StTrap:  trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control. Control outputs are packed
// as {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDest,RegWrite,
// ALUSrcA,ALUSrcB,ALUOp,PCSource} and compared against hand-derived per-state codes.
// CNT_W is reduced to 8 so the counter wrap is reachable in a short run.
module tb_multicycle_control;

    localparam int unsigned CNT_W = 8;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // Hand-derived output codes per state.
    localparam logic [15:0] C_FETCH_RDY  = 16'h9410;
    localparam logic [15:0] C_FETCH_WAIT = 16'h1010;
    localparam logic [15:0] C_DECODE     = 16'h0030;
    localparam logic [15:0] C_MEMADR     = 16'h0060;
    localparam logic [15:0] C_MEMRD      = 16'h3000;
    localparam logic [15:0] C_MEMWB      = 16'h0280;
    localparam logic [15:0] C_MEMWR      = 16'h2800;
    localparam logic [15:0] C_EXEC       = 16'h0048;
    localparam logic [15:0] C_ALUWB      = 16'h0180;
    localparam logic [15:0] C_BRANCH     = 16'h4045;
    localparam logic [15:0] C_ADDIWB     = 16'h0080;
    localparam logic [15:0] C_JUMP       = 16'h8002;
    localparam logic [15:0] C_ZERO       = 16'h0000;

    logic             clk;
    logic             rst;
    logic [31:0]      instrWord;
    logic             mem_ready;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic             MemToReg, RegDest, RegWrite, ALUSrcA;
    logic [1:0]       ALUSrcB, ALUOp, PCSource;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instr_count;

    int               checks;
    int               errors;
    logic [CNT_W-1:0] exp_count;

    multicycle_control #(
        .INSTR_W      (32),
        .MEM_WAIT_MAX (15),
        .CNT_W        (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instrWord   (instrWord),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemToReg    (MemToReg),
        .RegDest     (RegDest),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .trap        (trap),
        .trap_cause  (trap_cause),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] outs();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                RegDest, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
    endfunction

    // Leaves the DUT in FETCH, just after a falling edge, mem_ready low.
    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        exp_count = '0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        mem_ready = 1'b1;
        instrWord = {OP_LW, 26'h0};
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (outs() !== C_ZERO || trap !== 1'b0 || instr_count !== '0) begin
            errors++;
            $display("FAIL reset_hold outs=%h trap=%b cnt=%0d want 0000/0/0",
                     outs(), trap, instr_count);
        end
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_count = '0;
        #1;
        checks++;
        if (outs() !== C_FETCH_WAIT || trap !== 1'b0 || trap_cause !== 2'b00 ||
            instr_count !== '0) begin
            errors++;
            $display("FAIL reset_fetch outs=%h trap=%b cause=%b cnt=%0d want %h/0/00/0",
                     outs(), trap, trap_cause, instr_count, C_FETCH_WAIT);
        end
    endtask

    task automatic test_lw();
        logic [15:0] exp_seq [0:4];
        exp_seq   = '{C_FETCH_RDY, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB};
        mem_ready = 1'b1;
        instrWord = {OP_LW, 26'h0};
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (outs() !== exp_seq[i] || instr_count !== exp_count) begin
                errors++;
                $display("FAIL lw_step%0d outs=%h cnt=%0d want %h/%0d",
                         i, outs(), instr_count, exp_seq[i], exp_count);
            end
            @(negedge clk);
        end
        exp_count++;
        #1;
        checks++;
        if (instr_count !== exp_count || outs() !== C_FETCH_RDY) begin
            errors++;
            $display("FAIL lw_retire cnt=%0d outs=%h want %0d/%h",
                     instr_count, outs(), exp_count, C_FETCH_RDY);
        end
    endtask

    task automatic test_sw_wait();
        logic [15:0] exp_seq [0:6];
        logic        rdy     [0:6];
        exp_seq   = '{C_FETCH_RDY, C_DECODE, C_MEMADR, C_MEMWR, C_MEMWR, C_MEMWR, C_MEMWR};
        rdy       = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        instrWord = {OP_SW, 26'h0};
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (outs() !== exp_seq[i] || trap !== 1'b0) begin
                errors++;
                $display("FAIL sw_step%0d outs=%h trap=%b want %h/0",
                         i, outs(), trap, exp_seq[i]);
            end
            @(negedge clk);
        end
        exp_count++;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (instr_count !== exp_count || outs() !== C_FETCH_WAIT) begin
            errors++;
            $display("FAIL sw_retire cnt=%0d outs=%h want %0d/%h",
                     instr_count, outs(), exp_count, C_FETCH_WAIT);
        end
    endtask

    task automatic test_alu();
        logic [15:0] exp_r [0:3];
        logic [15:0] exp_a [0:3];
        exp_r     = '{C_FETCH_RDY, C_DECODE, C_EXEC, C_ALUWB};
        exp_a     = '{C_FETCH_RDY, C_DECODE, C_MEMADR, C_ADDIWB};
        mem_ready = 1'b1;
        instrWord = {OP_R, 26'h0};
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (outs() !== exp_r[i]) begin
                errors++;
                $display("FAIL rtype_step%0d outs=%h want %h", i, outs(), exp_r[i]);
            end
            @(negedge clk);
        end
        exp_count++;
        instrWord = {OP_ADDI, 26'h0};
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (outs() !== exp_a[i]) begin
                errors++;
                $display("FAIL addi_step%0d outs=%h want %h", i, outs(), exp_a[i]);
            end
            @(negedge clk);
        end
        exp_count++;
        #1;
        checks++;
        if (instr_count !== exp_count) begin
            errors++;
            $display("FAIL alu_retire cnt=%0d want %0d", instr_count, exp_count);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        // mem_ready arriving on the last permitted wait cycle still advances.
        for (int i = 0; i < 16; i++) begin
            mem_ready = (i == 15);
            #1;
            checks++;
            if (outs() !== (i == 15 ? C_FETCH_RDY : C_FETCH_WAIT) || trap !== 1'b0) begin
                errors++;
                $display("FAIL edge_wait%0d outs=%h trap=%b", i, outs(), trap);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (outs() !== C_DECODE || trap !== 1'b0) begin
            errors++;
            $display("FAIL edge_advance outs=%h trap=%b want %h/0", outs(), trap, C_DECODE);
        end
        do_reset();
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (trap !== 1'b0 || outs() !== C_FETCH_WAIT) begin
                errors++;
                $display("FAIL wait%0d trap=%b outs=%h want 0/%h", i, trap, outs(), C_FETCH_WAIT);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (trap !== 1'b1 || trap_cause !== 2'b10 || outs() !== C_ZERO) begin
            errors++;
            $display("FAIL timeout_trap trap=%b cause=%b outs=%h want 1/10/0000",
                     trap, trap_cause, outs());
        end
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (trap !== 1'b1 || trap_cause !== 2'b10) begin
            errors++;
            $display("FAIL trap_sticky trap=%b cause=%b want 1/10", trap, trap_cause);
        end
        do_reset();
        #1;
        checks++;
        if (trap !== 1'b0 || trap_cause !== 2'b00 || outs() !== C_FETCH_WAIT) begin
            errors++;
            $display("FAIL trap_recover trap=%b cause=%b outs=%h want 0/00/%h",
                     trap, trap_cause, outs(), C_FETCH_WAIT);
        end
    endtask

    task automatic test_illegal();
        logic [15:0] exp_seq [0:4];
        exp_seq   = '{C_FETCH_RDY, C_DECODE, C_ZERO, C_ZERO, C_ZERO};
        mem_ready = 1'b1;
        instrWord = {OP_BAD, 26'h3ff_ffff};
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (outs() !== exp_seq[i] || trap !== (i >= 2)) begin
                errors++;
                $display("FAIL illegal_step%0d outs=%h trap=%b want %h/%b",
                         i, outs(), trap, exp_seq[i], (i >= 2));
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (trap_cause !== 2'b01 || instr_count !== exp_count) begin
            errors++;
            $display("FAIL illegal_cause cause=%b cnt=%0d want 01/%0d",
                     trap_cause, instr_count, exp_count);
        end
        do_reset();
    endtask

    task automatic test_beq_j();
        logic [15:0] exp_b [0:2];
        logic [15:0] exp_j [0:2];
        exp_b = '{C_FETCH_RDY, C_DECODE, C_BRANCH};
`ifdef CTRL_JUMP_EN
        exp_j = '{C_FETCH_RDY, C_DECODE, C_JUMP};
`else
        exp_j = '{C_FETCH_RDY, C_DECODE, C_ZERO};
`endif
        mem_ready = 1'b1;
        instrWord = {OP_BEQ, 26'h0};
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs() !== exp_b[i]) begin
                errors++;
                $display("FAIL beq_step%0d outs=%h want %h", i, outs(), exp_b[i]);
            end
            @(negedge clk);
        end
        exp_count++;
        instrWord = {OP_J, 26'h0};
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs() !== exp_j[i] || instr_count !== exp_count) begin
                errors++;
                $display("FAIL j_step%0d outs=%h cnt=%0d want %h/%0d",
                         i, outs(), instr_count, exp_j[i], exp_count);
            end
            @(negedge clk);
        end
`ifdef CTRL_JUMP_EN
        exp_count++;
        #1;
        checks++;
        if (instr_count !== exp_count || trap !== 1'b0 || outs() !== C_FETCH_RDY) begin
            errors++;
            $display("FAIL j_retire cnt=%0d trap=%b outs=%h want %0d/0/%h",
                     instr_count, trap, outs(), exp_count, C_FETCH_RDY);
        end
`else
        #1;
        checks++;
        if (trap !== 1'b1 || trap_cause !== 2'b01 || instr_count !== exp_count) begin
            errors++;
            $display("FAIL j_trap trap=%b cause=%b cnt=%0d want 1/01/%0d",
                     trap, trap_cause, instr_count, exp_count);
        end
`endif
        do_reset();
    endtask

    task automatic test_count_wrap();
        do_reset();
        mem_ready = 1'b1;
        instrWord = {OP_BEQ, 26'h0};
        // 2^CNT_W-1 branches at three cycles each.
        repeat (3 * ((1 << CNT_W) - 1)) @(negedge clk);
        #1;
        checks++;
        if (instr_count !== {CNT_W{1'b1}} || outs() !== C_FETCH_RDY) begin
            errors++;
            $display("FAIL count_full cnt=%0d outs=%h want %0d/%h",
                     instr_count, outs(), (1 << CNT_W) - 1, C_FETCH_RDY);
        end
        instrWord = {OP_R, 26'h0};
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (instr_count !== '0) begin
            errors++;
            $display("FAIL count_wrap cnt=%0d want 0", instr_count);
        end
    endtask

    task automatic test_rst_exec();
        mem_ready = 1'b1;
        instrWord = {OP_R, 26'h0};
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (outs() !== C_EXEC) begin
            errors++;
            $display("FAIL rst_exec_reach outs=%h want %h", outs(), C_EXEC);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (outs() !== C_ZERO) begin
            errors++;
            $display("FAIL rst_exec_gate outs=%h want 0000", outs());
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (outs() !== C_FETCH_RDY || instr_count !== '0 || trap !== 1'b0) begin
            errors++;
            $display("FAIL rst_exec_fetch outs=%h cnt=%0d trap=%b want %h/0/0",
                     outs(), instr_count, trap, C_FETCH_RDY);
        end
        @(negedge clk);
        #1;
        checks++;
        if (outs() !== C_DECODE) begin
            errors++;
            $display("FAIL rst_exec_next outs=%h want %h", outs(), C_DECODE);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_count = '0;
        rst       = 1'b1;
        mem_ready = 1'b0;
        instrWord = '0;
        test_reset();
        test_lw();
        test_sw_wait();
        test_alu();
        test_timeout();
        test_illegal();
        test_beq_j();
        test_count_wrap();
        test_rst_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
